// File: rtl/fsm_stim_checker.sv
// Stimulus driver and golden-model checker for a small table-programmed FSM DUT.
// Run latency 2+2*NUM_STEPS cycles from start; no backpressure, start ignored while busy.
module fsm_stim_checker #(
  parameter int         SW_W      = 2,
  parameter int         STATE_W   = 3,
  parameter int         NUM_STEPS = 16,
  parameter int         STEP_W    = 8,
  parameter int         CNT_W     = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [STATE_W-1:0]                            cfg_init,
  input  logic [(2**STATE_W)*(2**SW_W)*STATE_W-1:0]     cfg_next,
  input  logic [(2**STATE_W)*(2**SW_W)-1:0]             cfg_out,
  output logic                                          dut_reset,
  output logic [STATE_W-1:0]                            dut_state_in,
  output logic [SW_W-1:0]                               dut_sw_in,
  output logic                                          dut_ctrl_in,
  input  logic [STATE_W-1:0]                            dut_state,
  input  logic                                          dut_out,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          pass,
  output logic [CNT_W-1:0]                              err_count,
  output logic [STEP_W-1:0]                             first_err_step,
  output logic                                          first_err_valid,
  output logic                                          err_state_seen,
  output logic                                          err_out_seen
);

  localparam int                IDX_W     = STATE_W + SW_W;
  localparam logic [7:0]        SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_CHK0,
    S_DRV,
    S_CHK,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          lfsr;
  logic                lfsr_fb;
  logic [STEP_W-1:0]   step;
  logic [STATE_W-1:0]  exp_state;
  logic                exp_out;
  logic [SW_W-1:0]     sw_q;
  logic [SW_W-1:0]     sw_cur;
  logic [IDX_W-1:0]    tbl_idx;
  logic [STATE_W-1:0]  tbl_next;
  logic                tbl_out;
  logic                state_mis;
  logic                out_mis;
  logic                chk_err;

  // Golden lookup uses the switch value being driven this cycle.
  assign sw_cur    = lfsr[SW_W-1:0];
  assign tbl_idx   = {exp_state, sw_cur};
  assign tbl_next  = cfg_next[int'(tbl_idx)*STATE_W +: STATE_W];
  assign tbl_out   = cfg_out[tbl_idx];
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign state_mis = (dut_state != exp_state);
  assign out_mis   = (dut_out != exp_out);
  assign chk_err   = ((state == S_CHK0) && state_mis) ||
                     ((state == S_CHK) && (state_mis || out_mis));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RST;
      S_RST:   state_nxt = S_CHK0;
      S_CHK0:  state_nxt = S_DRV;
      S_DRV:   state_nxt = S_CHK;
      S_CHK:   state_nxt = (step == LAST_STEP) ? S_DONE : S_DRV;
      S_DONE:  if (start) state_nxt = S_RST;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stimulus is decoded from state so an async reset drops it in the same cycle.
  always_comb begin
    dut_reset    = (state == S_RST);
    dut_state_in = (state == S_RST) ? cfg_init : '0;
    dut_ctrl_in  = (state == S_DRV);
    dut_sw_in    = (state == S_DRV) ? sw_cur : sw_q;
    busy         = (state == S_RST) || (state == S_CHK0) ||
                   (state == S_DRV) || (state == S_CHK);
    done         = (state == S_DONE);
    pass         = (state == S_DONE) && (err_count == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr            <= SEED;
      step            <= '0;
      exp_state       <= '0;
      exp_out         <= 1'b0;
      sw_q            <= '0;
      err_count       <= '0;
      first_err_step  <= '0;
      first_err_valid <= 1'b0;
      err_state_seen  <= 1'b0;
      err_out_seen    <= 1'b0;
    end else begin
      if (state_nxt == S_RST) begin
        sw_q <= '0;
      end
      case (state)
        S_RST: begin
          lfsr            <= SEED;
          step            <= '0;
          exp_state       <= cfg_init;
          exp_out         <= 1'b0;
          err_count       <= '0;
          first_err_step  <= '0;
          first_err_valid <= 1'b0;
          err_state_seen  <= 1'b0;
          err_out_seen    <= 1'b0;
        end
        S_DRV: begin
          exp_state <= tbl_next;
          exp_out   <= tbl_out;
          lfsr      <= {lfsr[6:0], lfsr_fb};
          step      <= step + 1'b1;
          sw_q      <= sw_cur;
        end
        default: begin
        end
      endcase
      if (chk_err) begin
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
        if (!first_err_valid) begin
          first_err_step  <= step;
          first_err_valid <= 1'b1;
        end
        if (state_mis) begin
          err_state_seen <= 1'b1;
        end
        if (out_mis && (state == S_CHK)) begin
          err_out_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_stim_checker.sv
// Bench for fsm_stim_checker: behavioural DUT with fault knobs, spec vectors and randomized runs.
module tb_fsm_stim_checker;
  localparam int NUM_STEPS = 16;
  localparam int NE        = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [2:0]  cfg_init;
  logic [95:0] cfg_next;
  logic [31:0] cfg_out;
  logic        dut_reset, dut_ctrl_in;
  logic [2:0]  dut_state_in;
  logic [1:0]  dut_sw_in;
  logic [2:0]  dut_state;
  logic        dut_out;
  logic        busy, done, pass, first_err_valid, err_state_seen, err_out_seen;
  logic [7:0]  err_count, first_err_step;
  logic        c4_dut_reset, c4_dut_ctrl_in, c4_busy, c4_done, c4_pass;
  logic        c4_fev, c4_sseen, c4_oseen;
  logic [2:0]  c4_dut_state_in;
  logic [1:0]  c4_dut_sw_in;
  logic [3:0]  c4_err_count;
  logic [7:0]  c4_first_err_step;

  fsm_stim_checker #(.CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cfg_init(cfg_init),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .dut_reset(dut_reset),
    .dut_state_in(dut_state_in), .dut_sw_in(dut_sw_in), .dut_ctrl_in(dut_ctrl_in),
    .dut_state(dut_state), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_step(first_err_step),
    .first_err_valid(first_err_valid), .err_state_seen(err_state_seen),
    .err_out_seen(err_out_seen));

  // Narrow-counter copy sees identical stimulus, so it can share the behavioural DUT.
  fsm_stim_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .cfg_init(cfg_init),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .dut_reset(c4_dut_reset),
    .dut_state_in(c4_dut_state_in), .dut_sw_in(c4_dut_sw_in), .dut_ctrl_in(c4_dut_ctrl_in),
    .dut_state(dut_state), .dut_out(dut_out), .busy(c4_busy), .done(c4_done), .pass(c4_pass),
    .err_count(c4_err_count), .first_err_step(c4_first_err_step),
    .first_err_valid(c4_fev), .err_state_seen(c4_sseen), .err_out_seen(c4_oseen));

  int         dut_mode;
  bit         f_inv, f_ign;
  int         f_flip_step, f_corrupt_step, dsteps;
  logic [2:0] tn[NE];
  logic       to[NE];

  function automatic logic [2:0] hand_next(logic [2:0] s, logic [1:0] sw);
    if (s == 3'd0) return (sw == 2'd0) ? 3'd0 : 3'd1;
    return (sw == 2'd0 || sw == 2'd2) ? 3'd1 : 3'd0;
  endfunction

  function automatic logic [2:0] m_next(logic [2:0] s, logic [1:0] sw);
    if (dut_mode == 0) return hand_next(s, sw);
    return tn[int'({s, sw})];
  endfunction

  function automatic logic m_out(logic [2:0] s, logic [1:0] sw);
    if (dut_mode == 0) return hand_next(s, sw) == 3'd1;
    return to[int'({s, sw})];
  endfunction

  always @(posedge clk) begin
    if (dut_reset) begin
      dut_state <= f_ign ? 3'd0 : dut_state_in;
      dsteps    <= 0;
    end else if (dut_ctrl_in) begin
      dut_state <= m_next(dut_state, dut_sw_in) ^ ((dsteps + 1 == f_corrupt_step) ? 3'd1 : 3'd0);
      dut_out   <= m_out(dut_state, dut_sw_in) ^ f_inv ^ (dsteps + 1 == f_flip_step);
      dsteps    <= dsteps + 1;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_opt(string name, logic [31:0] act, int exp);
    if (exp >= 0) chk(name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: replays the spec rules over whole trajectories of golden and DUT.
  int         m_cnt, m_fstep, m_fvalid, m_sseen, m_oseen;
  logic [1:0] m_sw[NUM_STEPS];

  task automatic model(input int init);
    int l, g, d, sw, eo, dov, idx_g, idx_d;
    l = 'hA5; g = init; d = f_ign ? 0 : init;
    m_cnt = 0; m_fstep = 0; m_fvalid = 0; m_sseen = 0; m_oseen = 0;
    if (d != g) begin
      m_cnt = 1; m_fvalid = 1; m_fstep = 0; m_sseen = 1;
    end
    for (int k = 1; k <= NUM_STEPS; k++) begin
      sw = l & 3;
      m_sw[k-1] = 2'(sw);
      idx_g = g * 4 + sw;
      idx_d = d * 4 + sw;
      eo  = int'(to[idx_g]);
      dov = int'(to[idx_d]) ^ ((k == f_flip_step) ? 1 : 0);
      g   = int'(tn[idx_g]);
      d   = int'(tn[idx_d]) ^ ((k == f_corrupt_step) ? 1 : 0);
      if (d != g || dov != eo) begin
        m_cnt++;
        if (m_fvalid == 0) begin
          m_fvalid = 1; m_fstep = k;
        end
      end
      if (d != g) m_sseen = 1;
      if (dov != eo) m_oseen = 1;
      l = ((l << 1) | (((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1)) & 255;
    end
  endtask

  task automatic pack_cfg;
    for (int i = 0; i < NE; i++) begin
      cfg_next[i*3 +: 3] = tn[i];
      cfg_out[i]         = to[i];
    end
  endtask

  task automatic load_hand_table;
    for (int i = 0; i < NE; i++) begin
      if (i < 8) begin
        tn[i] = hand_next(3'(i / 4), 2'(i % 4));
        to[i] = (tn[i] == 3'd1);
      end else begin
        tn[i] = 3'd0;
        to[i] = 1'b0;
      end
    end
    pack_cfg();
  endtask

  logic [1:0] swq[$];

  task automatic run(output int cyc);
    swq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_dut_reset", dut_reset, 1);
    chk("rst_busy", busy, 1);
    chk("rst_state_in", dut_state_in, cfg_init);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (dut_ctrl_in) swq.push_back(dut_sw_in);
      tick();
      cyc++;
    end
    chk("done_cycle", cyc, 2 + 2 * NUM_STEPS);
    chk("c4_done", c4_done, 1);
    chk("busy_at_done", busy, 0);
  endtask

  task automatic chk_sw(string name);
    int mis;
    mis = 0;
    if (swq.size() != NUM_STEPS) mis = 99;
    else for (int i = 0; i < NUM_STEPS; i++) if (swq[i] !== m_sw[i]) mis++;
    chk(name, mis, 0);
  endtask

  typedef struct {
    logic [2:0] init;
    bit         inv;
    bit         ign;
    int         cnt;
    int         fstep;
    int         fvalid;
    int         sseen;
    int         oseen;
    int         pas;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc, n, c4exp;
    vecs[0] = '{3'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1};
    vecs[1] = '{3'd0, 1'b1, 1'b0, 16, 1, 1, 0, 1, 0};
    vecs[2] = '{3'd1, 1'b0, 1'b1, -1, 0, 1, 1, -1, 0};
    vecs[3] = '{3'd1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1};
    vecs[4] = '{3'd1, 1'b1, 1'b0, 16, 1, 1, 0, 1, 0};

    dut_mode = 0; f_inv = 0; f_ign = 0; f_flip_step = 0; f_corrupt_step = 0;
    reset = 1'b0; start = 1'b0; cfg_init = 3'd0;
    load_hand_table();
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_fev", first_err_valid, 0);
    chk("reset_dut_reset", dut_reset, 0);
    chk("reset_ctrl", dut_ctrl_in, 0);
    chk("reset_sw", dut_sw_in, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      cfg_init = vecs[v].init; f_inv = vecs[v].inv; f_ign = vecs[v].ign;
      model(int'(vecs[v].init));
      run(cyc);
      chk_sw("vec_sw_seq");
      chk_opt("vec_err_count", err_count, vecs[v].cnt);
      chk("vec_first_step", first_err_step, vecs[v].fstep);
      chk("vec_first_valid", first_err_valid, vecs[v].fvalid);
      chk("vec_state_seen", err_state_seen, vecs[v].sseen);
      chk_opt("vec_out_seen", err_out_seen, vecs[v].oseen);
      chk("vec_pass", pass, vecs[v].pas);
      chk("vec_done", done, 1);
      c4exp = (vecs[v].cnt > 15) ? 15 : vecs[v].cnt;
      chk_opt("c4_err_count", c4_err_count, c4exp);
    end

    // Restart from DONE must reproduce the same stimulus and results.
    cfg_init = 3'd0; f_inv = 1; f_ign = 0;
    model(0);
    run(cyc);
    chk_sw("restart_sw_a");
    run(cyc);
    chk_sw("restart_sw_b");
    chk("restart_cnt", err_count, 16);
    chk("restart_fstep", first_err_step, 1);

    // A start pulse mid-run is ignored; done timing follows the first start.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    start = 1'b1; tick(); start = 1'b0;
    cyc = 11;
    while (!done && cyc < 200) begin tick(); cyc++; end
    chk("restart_ignored_cycle", cyc, 34);
    chk("restart_ignored_cnt", err_count, 16);

    // Async reset during step 5 aborts immediately.
    start = 1'b1; tick(); start = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 100) begin
      tick(); cyc++;
      if (dut_ctrl_in) n++;
    end
    chk("mid_reached_step5", n, 5);
    chk("mid_cnt_before", err_count, 4);
    #2 reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_ctrl", dut_ctrl_in, 0);
    chk("mid_cnt", err_count, 0);
    chk("mid_fev", first_err_valid, 0);
    chk("mid_sw", dut_sw_in, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_idle_done", done, 0);

    // Random tables with one injected fault kind per run.
    dut_mode = 1; f_inv = 0;
    for (int r = 0; r < 12; r++) begin
      int kind, fk;
      for (int i = 0; i < NE; i++) begin
        tn[i] = 3'($urandom_range(0, 7));
        to[i] = 1'($urandom_range(0, 1));
      end
      pack_cfg();
      cfg_init = 3'($urandom_range(0, 7));
      kind = r % 4;
      fk = $urandom_range(1, NUM_STEPS);
      f_ign = (kind == 3);
      f_flip_step = (kind == 1) ? fk : 0;
      f_corrupt_step = (kind == 2) ? fk : 0;
      model(int'(cfg_init));
      run(cyc);
      chk_sw("rnd_sw_seq");
      chk("rnd_err_count", err_count, m_cnt);
      chk("rnd_first_step", first_err_step, m_fstep);
      chk("rnd_first_valid", first_err_valid, m_fvalid);
      chk("rnd_state_seen", err_state_seen, m_sseen);
      chk("rnd_out_seen", err_out_seen, m_oseen);
      chk("rnd_pass", pass, (m_cnt == 0) ? 1 : 0);
      chk("rnd_c4_count", c4_err_count, (m_cnt > 15) ? 15 : m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
